// File: rtl/drum_pkg.sv
// Shared types and constants for the drum accumulator datapath.
// Holds the FSM state encoding, default widths and saturation bounds.
package drum_pkg;

   localparam int unsigned DefProdW = 16;
   localparam int unsigned DefAccW  = 24;
   localparam int unsigned DefLenW  = 6;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StHold = 2'd2
   } mac_state_e;

   // Largest signed value representable in w bits, carried at 64 bits.
   function automatic logic signed [63:0] acc_max(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] acc_min(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/drum_sat_add.sv
// Combinational signed saturating adder: acc (ACC_W) + sign-extended product (PROD_W).
// Clamps to the ACC_W signed range and flags the clamp on ovf.
module drum_sat_add
   import drum_pkg::*;
#(
   parameter int unsigned PROD_W = DefProdW,
   parameter int unsigned ACC_W  = DefAccW
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   localparam logic [ACC_W-1:0] AccMax = ACC_W'(acc_max(ACC_W));
   localparam logic [ACC_W-1:0] AccMin = ACC_W'(acc_min(ACC_W));

   logic [ACC_W:0] a_ext;
   logic [ACC_W:0] b_ext;
   logic [ACC_W:0] wide;

   always_comb begin
      a_ext = {a[ACC_W-1], a};
      b_ext = {{(ACC_W + 1 - PROD_W){b[PROD_W-1]}}, b};
      wide  = a_ext + b_ext;
      // One guard bit suffices: the two top bits disagree only on overflow.
      ovf   = wide[ACC_W] ^ wide[ACC_W-1];
      if (!ovf) begin
         sum = wide[ACC_W-1:0];
      end else if (wide[ACC_W]) begin
         sum = AccMin;
      end else begin
         sum = AccMax;
      end
   end

endmodule

// File: rtl/drum_mac_acc.sv
// Accumulates a programmed number of signed drum products into a saturating
// accumulator and hands the dot-product out over a valid/ready port.
module drum_mac_acc
   import drum_pkg::*;
#(
   parameter int unsigned PROD_W = DefProdW,
   parameter int unsigned ACC_W  = DefAccW,
   parameter int unsigned LEN_W  = DefLenW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_sat,
   output logic              busy
);

   mac_state_e        state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              sat_q, sat_d;

   logic [ACC_W-1:0]  add_sum;
   logic              add_ovf;

   drum_sat_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_sat_add (
      .a   (acc_q),
      .b   (in_prod),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = '0;
               sat_d   = 1'b0;
               cnt_d   = len;
               state_d = (len == '0) ? StHold : StAcc;
            end
         end
         StAcc: begin
            if (in_valid) begin
               acc_d = add_sum;
               sat_d = sat_q | add_ovf;
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            // start is deliberately not looked at here, even on the handoff cycle.
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      in_ready  = (state_q == StAcc);
      out_valid = (state_q == StHold);
      busy      = (state_q != StIdle);
      out_acc   = acc_q;
      out_sat   = sat_q;
   end

endmodule

// File: tb/tb_drum_mac_acc.sv
// Directed bench for drum_mac_acc: three instances (ACC_W 24/20/17) share stimulus
// so the saturation cases can be observed at different accumulator widths.
module tb_drum_mac_acc;

   logic               clk;
   logic               rst;
   logic               start;
   logic [5:0]         len;
   logic               in_valid;
   logic signed [15:0] in_prod;
   logic               out_ready;

   logic               in_ready_24, out_valid_24, out_sat_24, busy_24;
   logic signed [23:0] out_acc_24;
   logic               in_ready_20, out_valid_20, out_sat_20, busy_20;
   logic signed [19:0] out_acc_20;
   logic               in_ready_17, out_valid_17, out_sat_17, busy_17;
   logic signed [16:0] out_acc_17;

   int n_checks;
   int n_errors;

   drum_mac_acc #(.PROD_W(16), .ACC_W(24), .LEN_W(6)) u_dut24 (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready_24), .in_prod(in_prod),
      .out_valid(out_valid_24), .out_ready(out_ready), .out_acc(out_acc_24),
      .out_sat(out_sat_24), .busy(busy_24)
   );

   drum_mac_acc #(.PROD_W(16), .ACC_W(20), .LEN_W(6)) u_dut20 (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready_20), .in_prod(in_prod),
      .out_valid(out_valid_20), .out_ready(out_ready), .out_acc(out_acc_20),
      .out_sat(out_sat_20), .busy(busy_20)
   );

   drum_mac_acc #(.PROD_W(16), .ACC_W(17), .LEN_W(6)) u_dut17 (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready_17), .in_prod(in_prod),
      .out_valid(out_valid_17), .out_ready(out_ready), .out_acc(out_acc_17),
      .out_sat(out_sat_17), .busy(busy_17)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [5:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic signed [15:0] p);
      in_valid = 1'b1;
      in_prod  = p;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_prod   = '0;
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_in_ready", in_ready_24, 0);
      check("rst_out_valid", out_valid_24, 0);
      check("rst_busy", busy_24, 0);
      check("rst_out_acc", out_acc_24, 0);
      check("rst_out_sat", out_sat_24, 0);
      step();
      rst = 1'b0;
      step();

      // Basic: 100 - 20 + 5
      out_ready = 1'b1;
      start_run(6'd3);
      check("basic_in_ready", in_ready_24, 1);
      send(16'sd100);
      send(-16'sd20);
      check("basic_not_early", out_valid_24, 0);
      send(16'sd5);
      check("basic_out_valid", out_valid_24, 1);
      check("basic_out_acc", out_acc_24, 85);
      check("basic_out_sat", out_sat_24, 0);
      step();
      check("basic_idle", busy_24, 0);

      // Bubbles between products and output backpressure
      out_ready = 1'b0;
      start_run(6'd2);
      send(16'sd7);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bub_acc_wait", out_valid_24, 0);
      end
      send(16'sd9);
      for (int i = 0; i < 4; i++) begin
         check("bp_valid", out_valid_24, 1);
         check("bp_acc", out_acc_24, 16);
         check("bp_in_ready", in_ready_24, 0);
         step();
      end
      out_ready = 1'b1;
      step();
      check("bp_idle", busy_24, 0);

      // 63 x 32767: fits in 24 bits, saturates in 20 bits
      out_ready = 1'b0;
      start_run(6'd63);
      for (int i = 0; i < 63; i++) send(16'sd32767);
      check("pos24_valid", out_valid_24, 1);
      check("pos24_acc", out_acc_24, 2064321);
      check("pos24_sat", out_sat_24, 0);
      check("pos20_acc", out_acc_20, 524287);
      check("pos20_sat", out_sat_20, 1);
      out_ready = 1'b1;
      step();
      check("pos_idle", busy_24, 0);

      // Negative clamp at 17 bits, then recovery by +100
      out_ready = 1'b0;
      start_run(6'd4);
      send(-16'sd32768);
      send(-16'sd32768);
      send(-16'sd32768);
      send(16'sd100);
      check("neg17_valid", out_valid_17, 1);
      check("neg17_acc", out_acc_17, -65436);
      check("neg17_sat", out_sat_17, 1);
      check("neg24_acc", out_acc_24, -98204);
      check("neg24_sat", out_sat_24, 0);
      out_ready = 1'b1;
      step();

      // len=0 gives an immediate zero result; start on the handoff cycle is ignored
      out_ready = 1'b0;
      start_run(6'd0);
      check("len0_valid", out_valid_24, 1);
      check("len0_acc", out_acc_24, 0);
      check("len0_sat_cleared", out_sat_17, 0);
      out_ready = 1'b1;
      start     = 1'b1;
      len       = 6'd2;
      step();
      start = 1'b0;
      check("hold_start_ignored", busy_24, 0);
      step();
      check("no_new_run", busy_24, 0);

      // start during ACC must not reload the count
      out_ready = 1'b0;
      start_run(6'd2);
      start = 1'b1;
      len   = 6'd5;
      send(16'sd1);
      send(16'sd2);
      start = 1'b0;
      check("acc_start_valid", out_valid_24, 1);
      check("acc_start_acc", out_acc_24, 3);
      out_ready = 1'b1;
      step();
      check("acc_start_idle", busy_24, 0);

      // Async reset between clock edges mid-run
      out_ready = 1'b0;
      start_run(6'd5);
      send(16'sd10);
      send(16'sd20);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy_24, 0);
      check("arst_in_ready", in_ready_24, 0);
      check("arst_out_valid", out_valid_24, 0);
      check("arst_out_acc", out_acc_24, 0);
      check("arst_out_sat", out_sat_24, 0);
      #1 rst = 1'b0;
      step();
      check("arst_stays_idle", busy_24, 0);
      start_run(6'd1);
      send(-16'sd3);
      check("post_valid", out_valid_24, 1);
      check("post_acc", out_acc_24, -3);
      check("post_sat", out_sat_24, 0);
      out_ready = 1'b1;
      step();
      check("post_idle", busy_24, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/drum_mac_acc.md
Name: drum_mac_acc

Overview:
- Downstream consumer of the drum approximate multiplier. Accepts a stream of 16-bit signed products over a valid/ready handshake and accumulates a programmable number of them into a wide saturating accumulator.
- Presents the final dot-product with a valid/ready output handshake and a sticky saturation flag.
- Sits between the drum product register and the result readback path in the tile's register file.

Parameters:
- PROD_W, 16, product width; matches drum n+m.
- ACC_W, 24, accumulator width; must satisfy ACC_W > PROD_W.
- LEN_W, 6, width of the programmed accumulation length.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begins a new accumulation when idle.
- len  in  LEN_W  number of products to accumulate, sampled on accepted start.
- in_valid  in  1  product available.
- in_ready  out  1  block accepts a product this cycle.
- in_prod  in  PROD_W  signed two's-complement product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_acc  out  ACC_W  signed accumulated result.
- out_sat  out  1  at least one add in this run saturated.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, remaining count=0, out_sat=0. All outputs are 0 (in_ready, out_valid, busy, out_acc, out_sat). Reset mid-run discards the partial sum; no output is produced.
- States: IDLE, ACC, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 and len!=0: acc<=0, sat<=0, cnt<=len, then ACC.
  - start=1 and len==0: acc<=0, sat<=0, then HOLD. The result (0) is valid the next cycle.
- ACC:
  - in_ready=1.
  - On in_valid&in_ready: acc <= sat_add(acc, sext(in_prod)); cnt <= cnt-1.
  - If cnt==1 at that accept, go to HOLD.
  - No accept: hold all state; bubbles are allowed indefinitely.
- HOLD:
  - out_valid=1; out_acc and out_sat are stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE next cycle.
- Latency: out_valid rises the cycle after the final product is accepted.
- Throughput: one product per cycle in ACC.
- start is ignored outside IDLE, including in the same cycle HOLD hands off. start must be reasserted once IDLE is reached.
- len is sampled only on an accepted start; later changes have no effect on the current run.
- Arithmetic:
  - in_prod is sign-extended to ACC_W+1 and added to acc sign-extended to ACC_W+1.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value; if below -2^(ACC_W-1), clamp to that value. Either clamp sets sat (sticky for the run).
  - Further adds continue from the clamped value.
- Drum negative results are one's-complement inverted magnitudes and are summed as-is; the bias is part of the approximation and is not corrected here.
- out_acc reflects the internal acc register directly. It is defined only when out_valid=1; the bench checks it only then.

Decomposition:
- Shared package drum_pkg:
  - state enum (IDLE, ACC, HOLD).
  - default PROD_W/ACC_W/LEN_W constants.
  - ACC_MAX/ACC_MIN constant functions of ACC_W.
- One sub-module: drum_sat_add, combinational signed saturating adder. Ports: a[ACC_W], b[PROD_W], sum[ACC_W], ovf.
- FSM, counter and handshake stay in drum_mac_acc.

Test Plan:
- Basic: len=3, products 100, -20, 5 back-to-back, out_ready=1 → out_valid one cycle after the third accept, out_acc=85, out_sat=0, then IDLE.
- Bubbles and backpressure: len=2, products 7 and 9 with 3 idle cycles between, out_ready held 0 for 4 cycles → out_acc=16 stable throughout HOLD, in_ready=0 in HOLD, IDLE the cycle after out_ready=1.
- Positive saturation: ACC_W=24, len=63, every product 32767 → out_acc=2064321 (no saturation). Repeat with ACC_W=20 → out_acc=524287, out_sat=1.
- Negative saturation then recovery: ACC_W=17, products -32768, -32768, -32768, +100 → clamps at -65536 with sat set, final out_acc=-65436, out_sat=1.
- len=0 and ignored start: start with len=0 → out_valid next cycle with out_acc=0. Assert start during ACC and during the HOLD handshake cycle → no effect, no new run.
- Async reset mid-run: len=5, rst pulsed after 2 accepts, between clock edges → outputs 0 immediately. A subsequent run with len=1, product -3 gives out_acc=-3, out_sat=0.
